tdm_demux3: RTL and testbench
=============================

Name: tdm_demux3

Overview:
- Receive end of a 3:1 time-division link. Upstream, a 3-input mux driven by a rotating select serialises three lanes onto one bus.
- This block counts slots, steers each accepted beat into lane 0/1/2 of an assembly register, and presents the completed 3-lane frame.
- Valid/ready handshake on both sides; sync input for frame alignment.
- Sits between the shared link bus and lane consumers in the 74-series merge-cell designs.

Parameters:
- WIDTH, 1, bits per lane / per link beat.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- i_i  input  WIDTH  link data beat.
- valid_i  input  1  beat on i_i valid.
- sync_i  input  1  frame-start marker; qualifies the current beat as slot 0 (or realigns when idle).
- ready_o  output  1  beat accepted this cycle when valid_i && ready_o.
- y_o  output  3*WIDTH  frame; lane k at y_o[k*WIDTH +: WIDTH].
- valid_o  output  1  y_o holds an unconsumed frame.
- ready_i  input  1  downstream consumes the frame when valid_o && ready_i.
- s_o  output  2  current slot (0..2), i.e. the lane the next beat lands in.
- sync_err_o  output  1  one-cycle pulse: partial frame discarded by sync_i.

Behaviour:
- Reset (rst_ni low at an edge):
  - slot=0, assembly reg=0, y_o=0, valid_o=0, sync_err_o=0.
  - ready_o follows its combinational equation, which gives 1 after reset.
  - Reset mid-frame discards the partial frame and any held output frame without a pulse.
- Accept condition: acc = valid_i && ready_o.
- ready_o (combinational) = (slot!=2 && !sync_i) || !valid_o || ready_i.
  - Only a frame-completing beat can stall.
  - A sync beat is treated as possibly completing and is gated the same way.
- Slot rules on acc:
  - eff_slot = sync_i ? 0 : slot.
  - assembly[eff_slot] <= i_i.
  - slot <= eff_slot+1, wrapping 2 -> 0.
- Frame completion: acc with eff_slot==2.
  - y_o <= {i_i, assembly[1], assembly[0]}.
  - valid_o <= 1.
  - Zero extra latency: the frame is visible the cycle after the third beat.
- Output drain: valid_o && ready_i && !completion -> valid_o <= 0. y_o holds its value (not cleared).
- Simultaneous drain and completion in one cycle: valid_o stays 1 and y_o updates (back-to-back frames, full throughput).
- While valid_o=1 and !ready_i: y_o and valid_o are stable; beats for slots 0,1 are still accepted into the assembly register.
- sync_i handling:
  - sync_i && acc && slot!=0 -> sync_err_o=1 next cycle; the beat is written to lane 0 and slot becomes 1.
  - sync_i && !valid_i -> slot <= 0 and the partial frame is dropped; sync_err_o=1 next cycle if slot was !=0.
  - sync_i at slot==0 is legal; no error.
- sync_err_o is registered and high for exactly one cycle per event.
- Assembly lanes beyond the current slot keep stale data; they are never exposed because y_o loads only on completion.
- s_o = slot register (not eff_slot).

Decomposition:
- Package tdm_pkg:
  - NUM_SLOTS=3, SLOT_W=2.
  - typedef logic [SLOT_W-1:0] slot_t.
  - function next_slot(slot_t) implementing the wrap.
- Sub-module tdm_slot_cnt owns:
  - the mod-3 counter, with inputs adv, sync_i, rst_ni;
  - the sync_err_o register.
- The top level holds the assembly and output registers plus the handshake logic.

Test Plan (WIDTH=4):
- Reset then beats 0x1,0x2,0x3 with ready_i=1 -> one cycle after the 3rd beat: y_o=0x321, valid_o=1; s_o sequence 0,1,2,0.
- Continuous 6 beats 0xA..0xF with ready_i=1 -> ready_o constant 1; frames 0xCBA then 0xFED on consecutive completion cycles, no bubbles.
- Frame 0x321 held with ready_i=0, then beats 0x4,0x5 -> both accepted, y_o stays 0x321; beat 0x6 -> ready_o=0 until ready_i=1, then y_o=0x654.
- Beats 0x1,0x2, then beat 0x7 with sync_i=1 -> sync_err_o pulses once, s_o=1; then 0x8,0x9 -> y_o=0x987.
- sync_i pulse with valid_i=0 at s_o=0 -> no sync_err_o, s_o remains 0.
- rst_ni low for one cycle after beat 0x1 (and with valid_o=1 held) -> valid_o=0, y_o=0, s_o=0; the next three beats form a clean frame.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared slot definitions for the 3:1 TDM receive path.
// Holds the slot count, the slot type and the mod-3 wrap helper.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned SLOT_W    = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  function automatic slot_t next_slot(slot_t s);
    return (s == slot_t'(NUM_SLOTS - 1)) ? '0 : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Mod-3 slot counter with sync realignment.
// Also registers the one-cycle partial-frame-discard pulse.
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  adv_i,
  input  logic  sync_i,
  input  logic  valid_i,
  output slot_t slot_o,
  output slot_t eff_slot_o,
  output logic  sync_err_o
);

  slot_t slot_q, slot_d;
  logic  err_q, err_d;
  slot_t eff_slot;

  always_comb begin
    eff_slot = sync_i ? '0 : slot_q;
    slot_d   = slot_q;
    err_d    = 1'b0;
    if (adv_i) begin
      slot_d = next_slot(eff_slot);
      err_d  = sync_i && (slot_q != '0);
    end else if (sync_i && !valid_i) begin
      // Idle sync realigns; a partial frame in progress is dropped.
      slot_d = '0;
      err_d  = (slot_q != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  assign slot_o     = slot_q;
  assign eff_slot_o = eff_slot;
  assign sync_err_o = err_q;

endmodule

// File: rtl/tdm_demux3.sv
// Receive end of a 3:1 TDM link: steers beats into lanes and
// presents each completed 3-lane frame with a valid/ready handshake.
module tdm_demux3
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   i_i,
  input  logic               valid_i,
  input  logic               sync_i,
  output logic               ready_o,
  output logic [3*WIDTH-1:0] y_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         s_o,
  output logic               sync_err_o
);

  slot_t slot, eff_slot;
  logic  acc, complete;

  logic [NUM_SLOTS-1:0][WIDTH-1:0] asm_q, asm_d;
  logic [3*WIDTH-1:0]              y_q, y_d;
  logic                            valid_q, valid_d;

  // Only a beat that could complete a frame is held off by a full output.
  assign ready_o  = ((slot != slot_t'(2)) && !sync_i) || !valid_q || ready_i;
  assign acc      = valid_i && ready_o;
  assign complete = acc && (eff_slot == slot_t'(2));

  tdm_slot_cnt u_slot_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .adv_i      (acc),
    .sync_i     (sync_i),
    .valid_i    (valid_i),
    .slot_o     (slot),
    .eff_slot_o (eff_slot),
    .sync_err_o (sync_err_o)
  );

  always_comb begin
    asm_d   = asm_q;
    y_d     = y_q;
    valid_d = valid_q;
    if (acc) begin
      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
        if (eff_slot == slot_t'(k)) asm_d[k] = i_i;
      end
    end
    if (complete) begin
      y_d     = {i_i, asm_q[1], asm_q[0]};
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      asm_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign s_o     = slot;

endmodule

// File: tb/tb_tdm_demux3.sv
// Randomised and directed bench for tdm_demux3 with a frame scoreboard.
// The model tracks frames as lists of accepted beats.
module tb_tdm_demux3;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic [W-1:0]   i_i = '0;
  logic           valid_i = 1'b0;
  logic           sync_i = 1'b0;
  logic           ready_o;
  logic [3*W-1:0] y_o;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic [1:0]     s_o;
  logic           sync_err_o;

  always #5 clk = ~clk;

  tdm_demux3 #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .i_i        (i_i),
    .valid_i    (valid_i),
    .sync_i     (sync_i),
    .ready_o    (ready_o),
    .y_o        (y_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .s_o        (s_o),
    .sync_err_o (sync_err_o)
  );

  int checks = 0;
  int errors = 0;

  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   part[$];
  bit             out_full = 1'b0;
  bit             err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame monitor: a frame is consumed at the next edge when valid_o && ready_i.
  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected actual=%0h required=none", y_o);
      end else begin
        chk("y_o", 32'(y_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit r);
    bit exp_rdy;
    bit acc;
    valid_i = v;
    sync_i  = s;
    i_i     = d;
    ready_i = r;
    @(negedge clk);
    exp_rdy = (part.size() < 2 && !s) || !out_full || r;
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    chk("s_o", 32'(s_o), 32'(part.size()));
    chk("valid_o", 32'(valid_o), 32'(out_full));
    chk("sync_err_o", 32'(sync_err_o), 32'(err_exp));
    err_exp = 1'b0;
    acc = v && exp_rdy;
    if (acc) begin
      if (s) begin
        if (part.size() != 0) err_exp = 1'b1;
        part.delete();
      end
      part.push_back(d);
      if (part.size() == 3) begin
        exp_q.push_back({part[2], part[1], part[0]});
        part.delete();
        out_full = 1'b1;
      end else if (out_full && r) begin
        out_full = 1'b0;
      end
    end else begin
      if (s && !v) begin
        if (part.size() != 0) err_exp = 1'b1;
        part.delete();
      end
      if (out_full && r) out_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    sync_i  = 1'b0;
    ready_i = 1'b0;
    i_i     = '0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    part.delete();
    exp_q.delete();
    out_full = 1'b0;
    err_exp  = 1'b0;
    chk("rst_y_o", 32'(y_o), 32'h0);
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_s_o", 32'(s_o), 32'h0);
    chk("rst_sync_err_o", 32'(sync_err_o), 32'h0);
  endtask

  initial begin
    do_reset();

    // Basic frame
    step(1, 0, 4'h1, 1);
    step(1, 0, 4'h2, 1);
    step(1, 0, 4'h3, 1);
    step(0, 0, 4'h0, 1);

    // Back-to-back frames
    for (int k = 0; k < 6; k++) step(1, 0, 4'(4'hA + k), 1);
    step(0, 0, 4'h0, 1);

    // Held frame with partial beats accepted, third beat stalled
    step(1, 0, 4'h1, 0);
    step(1, 0, 4'h2, 0);
    step(1, 0, 4'h3, 0);
    step(1, 0, 4'h4, 0);
    step(1, 0, 4'h5, 0);
    step(1, 0, 4'h6, 0);
    step(1, 0, 4'h6, 0);
    step(1, 0, 4'h6, 1);
    step(0, 0, 4'h0, 1);

    // Sync mid-frame
    step(1, 0, 4'h1, 1);
    step(1, 0, 4'h2, 1);
    step(1, 1, 4'h7, 1);
    step(1, 0, 4'h8, 1);
    step(1, 0, 4'h9, 1);
    step(0, 0, 4'h0, 1);

    // Idle sync at slot 0
    step(0, 1, 4'h0, 1);
    step(0, 0, 4'h0, 1);

    // Reset with a held frame and a partial frame
    step(1, 0, 4'h1, 0);
    step(1, 0, 4'h2, 0);
    step(1, 0, 4'h3, 0);
    step(1, 0, 4'h1, 0);
    do_reset();
    step(1, 0, 4'hC, 1);
    step(1, 0, 4'hD, 1);
    step(1, 0, 4'hE, 1);
    step(0, 0, 4'h0, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6);
    end

    // Drain
    for (int n = 0; n < 4; n++) step(0, 0, 4'h0, 1);
    chk("frames_left", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
